// File: rtl/reorder_pkg.sv
// Shared types for the frame reorder controller.
//   rd_state_t : read-side FSM state (IDLE waits for a full bank, STREAM drains it).
package reorder_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

endpackage

// File: rtl/ram2p.sv
// Simple two-port RAM: one synchronous write port, one synchronous read port.
// Ports:
//   clk   : clock
//   wen   : write enable
//   waddr : write address (AW bits)
//   wdata : write data (DW bits)
//   raddr : read address (AW bits), sampled on clk
//   rdata : registered read data (DW bits)
module ram2p #(
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned WORDS = 2**AW;

  logic [DW-1:0] mem [WORDS];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/reorder_ctrl.sv
// Frame reorder controller: accepts words of a DEPTH-entry frame in any index
// order into one of two RAM banks, then streams completed frames out in index
// order. One bank fills while the other drains.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_vld/in_rdy/in_idx/in_data : write request (index within frame + payload)
//   out_vld/out_rdy/out_data/out_last : in-order output stream, out_last on index DEPTH-1
//   dup_err   : one-cycle pulse after an accepted write to an already-filled index
module reorder_ctrl
  import reorder_pkg::*;
#(
  parameter int unsigned DW = 18,
  parameter int unsigned IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [IW-1:0] in_idx,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          dup_err
);

  localparam int unsigned DEPTH = 2**IW;
  localparam int unsigned AW    = IW + 1;
  localparam int unsigned CW    = IW + 1;

  logic             wb;
  logic             rb;
  logic [1:0]       full;
  logic [DEPTH-1:0] bitmap [2];
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    rd_ptr;
  rd_state_t        state;

  logic             wr_acc_c;
  logic             wr_hit_c;
  logic             wr_new_c;
  logic             fill_done_c;
  logic             xfer_c;
  logic             drain_done_c;
  logic [AW-1:0]    waddr_c;
  logic [AW-1:0]    raddr_c;

  // Write-side handshake and classification of the accepted write.
  assign in_rdy       = !full[wb];
  assign wr_acc_c     = in_vld && in_rdy;
  assign wr_hit_c     = bitmap[wb][in_idx];
  assign wr_new_c     = wr_acc_c && !wr_hit_c;
  assign fill_done_c  = wr_new_c && (cnt == CW'(DEPTH - 1));
  assign waddr_c      = {wb, in_idx};

  // Read-side transfer and end-of-frame detection.
  assign xfer_c       = (state == STREAM) && out_vld && out_rdy;
  assign drain_done_c = xfer_c && (rd_ptr == IW'(DEPTH - 1));

  // Read address runs one index ahead on a transfer so the RAM's registered
  // output already holds the next word when the new index is presented.
  always_comb begin
    raddr_c = {rb, rd_ptr};
    if (state == IDLE) begin
      raddr_c = {rb, IW'(0)};
    end else if (xfer_c) begin
      raddr_c = {rb, IW'(rd_ptr + IW'(1))};
    end
  end

  // Fill tracking: bitmaps, fill counter, bank full flags, write bank pointer.
  // Fill and drain touch different banks, so both may complete in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb        <= 1'b0;
      cnt       <= '0;
      full      <= '0;
      bitmap[0] <= '0;
      bitmap[1] <= '0;
      dup_err   <= 1'b0;
    end else begin
      dup_err <= wr_acc_c && wr_hit_c;
      if (wr_new_c) begin
        bitmap[wb][in_idx] <= 1'b1;
        if (fill_done_c) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (drain_done_c) begin
        full[rb]   <= 1'b0;
        bitmap[rb] <= '0;
      end
    end
  end

  // Read FSM: waits for the read bank to fill, then presents one index per transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rb       <= 1'b0;
      rd_ptr   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rb]) begin
            out_vld  <= 1'b1;
            out_last <= 1'b0;
            rd_ptr   <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (xfer_c) begin
            if (drain_done_c) begin
              out_vld  <= 1'b0;
              out_last <= 1'b0;
              rd_ptr   <= '0;
              rb       <= ~rb;
              state    <= IDLE;
            end else begin
              rd_ptr   <= rd_ptr + IW'(1);
              out_last <= (rd_ptr == IW'(DEPTH - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram2p #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .wen   (wr_new_c),
    .waddr (waddr_c),
    .wdata (in_data),
    .raddr (raddr_c),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_reorder_ctrl.sv
// Self-checking bench for reorder_ctrl at IW=2 (DEPTH=4): directed vector table,
// hand-written multi-cycle sequences, and randomized traffic against a frame-level model.
module tb_reorder_ctrl;

  localparam int unsigned DW = 18;
  localparam int unsigned IW = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [IW-1:0] in_idx;
  logic [DW-1:0] in_data;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          dup_err;

  int tests  = 0;
  int failed = 0;

  reorder_ctrl #(.DW(DW), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_idx   (in_idx),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_last (out_last),
    .dup_err  (dup_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          vld;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          ordy;
    logic          e_irdy;
    logic          e_ovld;
    logic [DW-1:0] e_data;
    logic          e_last;
    logic          e_dup;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic v, input int idx, input int data, input logic ordy,
                     input logic eovld, input int edata, input logic elast, input logic edup);
    vec_t r;
    r.vld = v; r.idx = IW'(idx); r.data = DW'(data); r.ordy = ordy;
    r.e_irdy = 1'b1; r.e_ovld = eovld; r.e_data = DW'(edata);
    r.e_last = elast; r.e_dup = edup;
    tbl.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0; in_idx = '0; in_data = '0; out_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write(input int idx, input int data);
    in_vld = 1'b1; in_idx = IW'(idx); in_data = DW'(data);
    tick();
    in_vld = 1'b0;
  endtask

  // Waits (bounded) for a frame and checks its four words in order with out_rdy held high.
  task automatic expect_frame(input string name, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] w [4];
    int n;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    out_rdy = 1'b1;
    n = 0;
    while (!out_vld && n < 10) begin
      tick();
      n++;
    end
    chk({name, "_start"}, 32'(out_vld), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_data%0d", name, k), 32'(out_data), 32'(w[k]));
      chk($sformatf("%s_last%0d", name, k), 32'(out_last), 32'(k == 3));
      tick();
    end
    chk({name, "_end"}, 32'(out_vld), 32'd0);
  endtask

  // Frame-level model state for the randomized phase.
  logic [DW-1:0] wq[$];
  logic [DW-1:0] cur [4];
  bit            filled [4];
  int            nfill;
  int            nfull;
  int            rd_pos;
  bit            exp_dup;

  task automatic model_clear();
    wq.delete();
    for (int i = 0; i < 4; i++) filled[i] = 1'b0;
    nfill = 0; nfull = 0; rd_pos = 0; exp_dup = 1'b0;
  endtask

  task automatic rnd_cycle(input bit flush);
    bit acc, xfer;
    chk("rnd_in_rdy", 32'(in_rdy), 32'(nfull < 2));
    chk("rnd_dup", 32'(dup_err), 32'(exp_dup));
    chk("rnd_vld_no_frame", 32'(out_vld && nfull == 0), 32'd0);
    in_vld  = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
    in_idx  = IW'($urandom_range(0, DEPTH - 1));
    in_data = DW'($urandom);
    out_rdy = flush ? 1'b1 : ($urandom_range(0, 9) < 6);
    acc  = in_vld && in_rdy;
    xfer = out_vld && out_rdy;
    if (xfer) begin
      if (wq.size() == 0) begin
        chk("rnd_xfer_empty", 32'd1, 32'd0);
      end else begin
        chk("rnd_data", 32'(out_data), 32'(wq[0]));
        chk("rnd_last", 32'(out_last), 32'(rd_pos == 3));
        void'(wq.pop_front());
        rd_pos++;
        if (rd_pos == 4) begin
          rd_pos = 0;
          nfull--;
        end
      end
    end
    exp_dup = 1'b0;
    if (acc) begin
      if (filled[in_idx]) begin
        exp_dup = 1'b1;
      end else begin
        cur[in_idx] = in_data;
        filled[in_idx] = 1'b1;
        nfill++;
        if (nfill == 4) begin
          for (int i = 0; i < 4; i++) begin
            wq.push_back(cur[i]);
            filled[i] = 1'b0;
          end
          nfill = 0;
          nfull++;
        end
      end
    end
    tick();
  endtask

  initial begin
    logic [DW-1:0] f0 [4];
    logic [DW-1:0] f1 [4];
    int perm0 [4];
    int perm1 [4];

    // Directed table: each row drives one cycle, expectations are the outputs after that edge.
    // Frame A: idx 3,1,0,2 -> A0..A3 streamed two cycles after the completing write.
    add(1, 3, 'h3A3, 1, 0, 0, 0, 0);
    add(1, 1, 'h3A1, 1, 0, 0, 0, 0);
    add(1, 0, 'h3A0, 1, 0, 0, 0, 0);
    add(1, 2, 'h3A2, 1, 0, 0, 0, 0);
    add(0, 0, 0,      1, 1, 'h3A0, 0, 0);
    add(0, 0, 0,      1, 1, 'h3A1, 0, 0);
    add(0, 0, 0,      1, 1, 'h3A2, 0, 0);
    add(0, 0, 0,      1, 1, 'h3A3, 1, 0);
    add(0, 0, 0,      1, 0, 0, 0, 0);
    // Frame with a duplicate index 0: one dup pulse, duplicate dropped.
    add(1, 0, 'h0B,  1, 0, 0, 0, 0);
    add(1, 0, 'h0C,  1, 0, 0, 0, 1);
    add(1, 1, 'h0D,  1, 0, 0, 0, 0);
    add(1, 2, 'h0E,  1, 0, 0, 0, 0);
    add(1, 3, 'h0F,  1, 0, 0, 0, 0);
    add(0, 0, 0,     1, 1, 'h0B, 0, 0);
    add(0, 0, 0,     1, 1, 'h0D, 0, 0);
    add(0, 0, 0,     1, 1, 'h0E, 0, 0);
    add(0, 0, 0,     1, 1, 'h0F, 1, 0);
    add(0, 0, 0,     1, 0, 0, 0, 0);
    // Frame G with out_rdy stalls: every word held until transferred.
    add(1, 0, 'h1230, 1, 0, 0, 0, 0);
    add(1, 1, 'h1231, 1, 0, 0, 0, 0);
    add(1, 2, 'h1232, 1, 0, 0, 0, 0);
    add(1, 3, 'h1233, 1, 0, 0, 0, 0);
    add(0, 0, 0,      0, 1, 'h1230, 0, 0);
    add(0, 0, 0,      1, 1, 'h1231, 0, 0);
    add(0, 0, 0,      0, 1, 'h1231, 0, 0);
    add(0, 0, 0,      0, 1, 'h1231, 0, 0);
    add(0, 0, 0,      1, 1, 'h1232, 0, 0);
    add(0, 0, 0,      1, 1, 'h1233, 1, 0);
    add(0, 0, 0,      0, 1, 'h1233, 1, 0);
    add(0, 0, 0,      1, 0, 0, 0, 0);

    do_reset();
    chk("reset_out_vld", 32'(out_vld), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_dup_err", 32'(dup_err), 32'd0);
    chk("reset_in_rdy", 32'(in_rdy), 32'd1);

    foreach (tbl[i]) begin
      in_vld = tbl[i].vld; in_idx = tbl[i].idx; in_data = tbl[i].data; out_rdy = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].e_irdy));
      chk($sformatf("vec%0d_out_vld", i), 32'(out_vld), 32'(tbl[i].e_ovld));
      chk($sformatf("vec%0d_dup", i), 32'(dup_err), 32'(tbl[i].e_dup));
      if (tbl[i].e_ovld) begin
        chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
        chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].e_last));
      end
    end
    in_vld = 1'b0;

    // Two frames filled behind a stalled output: writes blocked until bank 0 drains.
    do_reset();
    perm0 = '{2, 0, 3, 1};
    perm1 = '{1, 3, 0, 2};
    for (int k = 0; k < 4; k++) begin
      f0[k] = DW'(32'h100 + k);
      f1[k] = DW'(32'h200 + k);
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("bp_in_rdy%0d", k), 32'(in_rdy), 32'd1);
      if (k < 4) write(perm0[k], 32'(f0[perm0[k]]));
      else       write(perm1[k-4], 32'(f1[perm1[k-4]]));
    end
    chk("bp_blocked", 32'(in_rdy), 32'd0);
    chk("bp_out_vld", 32'(out_vld), 32'd1);
    chk("bp_first", 32'(out_data), 32'(f0[0]));
    in_vld = 1'b1; in_idx = '0; in_data = DW'(32'h3FFFF);
    tick();
    tick();
    chk("bp_still_blocked", 32'(in_rdy), 32'd0);
    chk("bp_no_dup", 32'(dup_err), 32'd0);
    in_vld = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_f0_data%0d", k), 32'(out_data), 32'(f0[k]));
      chk($sformatf("bp_f0_last%0d", k), 32'(out_last), 32'(k == 3));
      chk($sformatf("bp_f0_in_rdy%0d", k), 32'(in_rdy), 32'd0);
      tick();
    end
    chk("bp_in_rdy_after", 32'(in_rdy), 32'd1);
    chk("bp_gap", 32'(out_vld), 32'd0);
    expect_frame("bp_f1", f1[0], f1[1], f1[2], f1[3]);

    // Reset in the middle of a frame discards it; the next frame drains cleanly.
    do_reset();
    write(0, 32'h3111);
    write(1, 32'h3222);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
    write(2, 32'h0C2);
    write(0, 32'h0C0);
    write(3, 32'h0C3);
    chk("mid_rst_partial", 32'(out_vld), 32'd0);
    write(1, 32'h0C1);
    expect_frame("mid_rst_frame", DW'(32'h0C0), DW'(32'h0C1), DW'(32'h0C2), DW'(32'h0C3));

    // Randomized traffic against the frame-level model, then a bounded drain.
    do_reset();
    model_clear();
    for (int c = 0; c < 4000; c++) rnd_cycle(1'b0);
    for (int c = 0; c < 40; c++) rnd_cycle(1'b1);
    chk("rnd_drained", 32'(nfull), 32'd0);
    chk("rnd_final_vld", 32'(out_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reorder_ctrl.md
REORDER_CTRL -- requirements
Module: reorder_ctrl

Interface
REQ-001 Parameter DW, default 18, data word width.
REQ-002 Parameter IW, default 6, index width; frame depth DEPTH = 2**IW; RAM address width AW = IW+1, derived.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_vld  input  1  write request valid.
REQ-006 in_rdy  output  1  write request accepted when in_vld & in_rdy.
REQ-007 in_idx  input  IW  in-frame sequence index of the write (any order).
REQ-008 in_data  input  DW  write payload.
REQ-009 out_vld  output  1  in-order output valid.
REQ-010 out_rdy  input  1  downstream ready; transfer when out_vld & out_rdy.
REQ-011 out_data  output  DW  payload of current output index.
REQ-012 out_last  output  1  high with out_vld when current output index = DEPTH-1.
REQ-013 dup_err  output  1  one-cycle pulse: accepted write hit an already-filled index.

Function
REQ-014 Two banks (bit AW-1 of the RAM address); write bank pointer wb, read bank pointer rb, per-bank full flag, per-bank DEPTH-bit fill bitmap, one fill counter (IW+1 bits).
REQ-015 in_rdy = !full[wb], combinational.
REQ-016 Accepted write with bitmap[wb][in_idx]=0: RAM write at {wb,in_idx}, set bitmap bit, increment counter.
REQ-017 Accepted write with bitmap bit already 1: no RAM write, no count, dup_err=1 next cycle.
REQ-018 Counter reaching DEPTH on an accepted write: full[wb] set, wb toggled, counter cleared at that same edge.
REQ-019 Read FSM states IDLE, STREAM; rd_ptr (IW bits) = index currently presented.
REQ-020 IDLE: if full[rb], drive RAM read address {rb,0}, set out_vld, rd_ptr=0, go STREAM.
REQ-021 STREAM: RAM read address = {rb, rd_ptr+1} on a transfer, else {rb, rd_ptr} (combinational); out_data = RAM read data directly.
REQ-022 STREAM transfer with rd_ptr<DEPTH-1: rd_ptr increments; out_vld stays 1.
REQ-023 STREAM transfer with rd_ptr=DEPTH-1: clear full[rb] and bitmap[rb], toggle rb, out_vld=0, go IDLE.
REQ-024 Latency: first out_vld two cycles after the frame-completing write is accepted; thereafter one word per cycle while out_rdy=1.
REQ-025 Stall (out_rdy=0): out_data and out_last hold stable.
REQ-026 Both banks full: in_rdy=0 until the drain of rb completes; in_rdy rises the cycle after.
REQ-027 Completion of a fill and completion of a drain in the same cycle both take effect; flags are per-bank, no priority needed.
REQ-028 Writes never target the bank being drained; no read/write address collision.

Reset
REQ-029 rst: wb=0, rb=0, full=0, bitmaps=0, counter=0, rd_ptr=0, FSM=IDLE, out_vld=0, dup_err=0, in_rdy=1 in the following cycle.
REQ-030 RAM contents not reset; out_data undefined while out_vld=0.
REQ-031 rst mid-frame or mid-drain discards all partial and full frames.

Structure
REQ-032 Package reorder_pkg holds the read FSM state enum.
REQ-033 One sub-module: ram2p instance, DW=DW, AW=IW+1, wen/addresses driven by this block.

Verification (IW=2, DEPTH=4)
REQ-034 Writes idx 3,1,0,2 data A3,A1,A0,A2, out_rdy=1 -> out_data A0,A1,A2,A3 on consecutive cycles, first 2 cycles after last write, out_last with A3.
REQ-035 Frame 0 filled then frame 1 filled while out_rdy=0 -> in_rdy=0 after 8 accepts; frame 0 drains; in_rdy=1 next cycle; frame 1 then drains in order.
REQ-036 Writes idx 0,0,1,2,3 data B,C,D,E,F -> dup_err pulse once; output B,D,E,F.
REQ-037 out_rdy toggling 1,0,0,1 during drain -> each word presented until transferred, no loss or repeat.
REQ-038 rst after 2 writes of a frame -> out_vld=0, in_rdy=1; next full frame of 4 drains correctly from bank 0.
